// File: rtl/image_rd_ctrl.sv
// Read-side controller for the image memory: walks a 2-D region, issues one read
// per cycle, and returns the words as a credit-protected ready/valid stream.
module image_rd_ctrl #(
   parameter int GROUP_NB   = 4,
   parameter int IMG_WIDTH  = 16,
   parameter int MEM_AWIDTH = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cfg_val,
   output logic                          cfg_rdy,
   input  logic [MEM_AWIDTH-1:0]         cfg_base,
   input  logic [MEM_AWIDTH-1:0]         cfg_cols,
   input  logic [MEM_AWIDTH-1:0]         cfg_rows,
   input  logic [MEM_AWIDTH-1:0]         cfg_pitch,
   input  logic                          mem_wr_val,
   output logic                          mem_rd_val,
   output logic [MEM_AWIDTH-1:0]         mem_rd_addr,
   input  logic [GROUP_NB*IMG_WIDTH-1:0] mem_rd_data,
   input  logic                          mem_rd_data_val,
   output logic [GROUP_NB*IMG_WIDTH-1:0] img_data,
   output logic                          img_val,
   input  logic                          img_rdy,
   output logic                          img_last,
   output logic                          busy,
   output logic                          done,
   output logic [1:0]                    state_dbg
);

   localparam int DW = GROUP_NB * IMG_WIDTH;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int TW = 2 * MEM_AWIDTH;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                state;
   logic [MEM_AWIDTH-1:0] row_start, col, row;
   logic [MEM_AWIDTH-1:0] cols_q, rows_q, pitch_q;
   logic [TW-1:0]         total_q, pop_cnt;
   logic [CW-1:0]         inflight, fifo_count;
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [DW-1:0]         fifo_mem [FIFO_DEPTH];

   logic issue, push, pop, last_addr, end_of_row;

   // Valid/ready: a stream word transfers on any cycle where img_val and img_rdy
   // are both high; img_val never depends on img_rdy.
   assign cfg_rdy   = (state == IDLE);
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign state_dbg = state;

   // A credit is every FIFO slot not already filled or promised to an in-flight read.
   assign issue       = (state == RUN) &&
                        (({1'b0, fifo_count} + {1'b0, inflight}) < (CW+1)'(FIFO_DEPTH));
   assign mem_rd_val  = issue && !mem_wr_val;
   assign mem_rd_addr = row_start + col;
   assign end_of_row  = (col == cols_q - MEM_AWIDTH'(1));
   assign last_addr   = end_of_row && (row == rows_q - MEM_AWIDTH'(1));

   assign push     = mem_rd_data_val && (state != IDLE);
   assign img_val  = (fifo_count != '0);
   assign pop      = img_val && img_rdy;
   assign img_data = fifo_mem[rd_ptr];
   assign img_last = img_val && (pop_cnt == total_q - TW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         row_start <= '0;
         col       <= '0;
         row       <= '0;
         cols_q    <= '0;
         rows_q    <= '0;
         pitch_q   <= '0;
         total_q   <= '0;
         pop_cnt   <= '0;
      end else begin
         if (pop) pop_cnt <= pop_cnt + TW'(1);
         case (state)
            IDLE: begin
               if (cfg_val) begin
                  row_start <= cfg_base;
                  col       <= '0;
                  row       <= '0;
                  cols_q    <= cfg_cols;
                  rows_q    <= cfg_rows;
                  pitch_q   <= cfg_pitch;
                  total_q   <= TW'(cfg_rows) * TW'(cfg_cols);
                  pop_cnt   <= '0;
                  state     <= (cfg_rows == '0 || cfg_cols == '0) ? DONE : RUN;
               end
            end
            RUN: begin
               if (mem_rd_val) begin
                  if (last_addr) begin
                     state <= DRAIN;
                  end else if (end_of_row) begin
                     col       <= '0;
                     row       <= row + MEM_AWIDTH'(1);
                     row_start <= row_start + pitch_q;
                  end else begin
                     col <= col + MEM_AWIDTH'(1);
                  end
               end
            end
            // Popping the final word implies nothing is left in flight or buffered.
            DRAIN:   if (pop && img_last) state <= DONE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight   <= '0;
         fifo_count <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
      end else begin
         case ({mem_rd_val, push})
            2'b10:   inflight <= inflight + CW'(1);
            2'b01:   inflight <= inflight - CW'(1);
            default: inflight <= inflight;
         endcase
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
         if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= mem_rd_data;
   end

endmodule

// File: tb/tb_image_rd_ctrl.sv
// Directed bench for image_rd_ctrl with a 3-cycle read-latency memory model and
// an address/data scoreboard.
module tb_image_rd_ctrl;

   localparam int AW = 16;
   localparam int DW = 64;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cfg_val, cfg_rdy;
   logic [AW-1:0] cfg_base, cfg_cols, cfg_rows, cfg_pitch;
   logic          mem_wr_val, mem_rd_val;
   logic [AW-1:0] mem_rd_addr;
   logic [DW-1:0] mem_rd_data;
   logic          mem_rd_data_val;
   logic [DW-1:0] img_data;
   logic          img_val, img_rdy, img_last, busy, done;
   logic [1:0]    state_dbg;

   image_rd_ctrl #(.GROUP_NB(4), .IMG_WIDTH(16), .MEM_AWIDTH(AW), .FIFO_DEPTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_val(cfg_val), .cfg_rdy(cfg_rdy),
      .cfg_base(cfg_base), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows), .cfg_pitch(cfg_pitch),
      .mem_wr_val(mem_wr_val), .mem_rd_val(mem_rd_val), .mem_rd_addr(mem_rd_addr),
      .mem_rd_data(mem_rd_data), .mem_rd_data_val(mem_rd_data_val),
      .img_data(img_data), .img_val(img_val), .img_rdy(img_rdy), .img_last(img_last),
      .busy(busy), .done(done), .state_dbg(state_dbg)
   );

   // clock / reset / cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // memory model: fixed 3-cycle read latency, not affected by the DUT reset
   function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
      return {a, ~a, a ^ 16'hA5C3, a + 16'd7};
   endfunction

   logic [2:0]    pv = '0;
   logic [AW-1:0] pa [3];
   always @(posedge clk) begin
      pv    <= {pv[1:0], mem_rd_val};
      pa[2] <= pa[1];
      pa[1] <= pa[0];
      pa[0] <= mem_rd_addr;
   end
   assign mem_rd_data_val = pv[2];
   assign mem_rd_data     = word_of(pa[2]);

   // checking
   int n_checks = 0;
   int n_errors = 0;
   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // scoreboard
   logic [AW-1:0] exp_addr_q[$];
   logic [DW-1:0] exp_q[$];
   int rd_cnt, pop_cnt, done_cnt;
   int first_rd_cyc, last_rd_cyc, first_val_cyc, last_pop_cyc, done_cyc;
   int t_acc;

   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_wr_val) check("rd_during_wr", mem_rd_val, 0);
         if (mem_rd_val) begin
            if (rd_cnt == 0) first_rd_cyc = cyc;
            last_rd_cyc = cyc;
            rd_cnt++;
            if (exp_addr_q.size() == 0) check("rd_unexpected", mem_rd_val, 0);
            else check("rd_addr", mem_rd_addr, exp_addr_q.pop_front());
         end
         if (img_val && first_val_cyc < 0) first_val_cyc = cyc;
         if (img_val && img_rdy) begin
            pop_cnt++;
            last_pop_cyc = cyc;
            if (exp_q.size() == 0) check("img_unexpected", img_val, 0);
            else begin
               check("img_last", img_last, (exp_q.size() == 1));
               check("img_data", img_data, exp_q.pop_front());
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   // driver tasks
   task automatic clear_stats();
      rd_cnt = 0; pop_cnt = 0; done_cnt = 0;
      first_rd_cyc = -1; last_rd_cyc = -1; first_val_cyc = -1;
      last_pop_cyc = -1; done_cyc = -1;
      exp_addr_q.delete();
      exp_q.delete();
   endtask

   task automatic exp_addr(input logic [AW-1:0] a);
      exp_addr_q.push_back(a);
      exp_q.push_back(word_of(a));
   endtask

   // Returns at #1 into the cycle after acceptance (T+1); fields are scrambled then.
   task automatic send_cfg(input logic [AW-1:0] b, input logic [AW-1:0] c,
                           input logic [AW-1:0] r, input logic [AW-1:0] p);
      int k;
      @(posedge clk); #1;
      k = 0;
      while (!cfg_rdy && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      check("cfg_rdy_before_send", cfg_rdy, 1);
      cfg_val = 1'b1; cfg_base = b; cfg_cols = c; cfg_rows = r; cfg_pitch = p;
      t_acc = cyc;
      @(posedge clk); #1;
      cfg_val   = 1'b0;
      cfg_base  = AW'($urandom_range(0, 65535));
      cfg_cols  = AW'($urandom_range(1, 65535));
      cfg_rows  = AW'($urandom_range(1, 65535));
      cfg_pitch = AW'($urandom_range(0, 65535));
   endtask

   task automatic wait_done(input int budget);
      int k;
      k = 0;
      while (done_cnt == 0 && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      repeat (3) @(posedge clk);
      #1;
      check("done_pulses", done_cnt, 1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_cfg_rdy"}, cfg_rdy, 1);
      check({tag, "_rd_val"}, mem_rd_val, 0);
      check({tag, "_img_val"}, img_val, 0);
      check({tag, "_img_last"}, img_last, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_state"}, state_dbg, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; cfg_val = 1'b0;
      cfg_base = '0; cfg_cols = '0; cfg_rows = '0; cfg_pitch = '0;
      mem_wr_val = 1'b0; img_rdy = 1'b1;
      clear_stats();
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // basic region
      clear_stats();
      exp_addr(16'h10); exp_addr(16'h11); exp_addr(16'h12); exp_addr(16'h13);
      exp_addr(16'h30); exp_addr(16'h31); exp_addr(16'h32); exp_addr(16'h33);
      send_cfg(16'h10, 16'd4, 16'd2, 16'h20);
      wait_done(100);
      check("basic_first_rd", first_rd_cyc - t_acc, 1);
      check("basic_last_rd", last_rd_cyc - t_acc, 8);
      check("basic_first_val", first_val_cyc - t_acc, 5);
      check("basic_rd_cnt", rd_cnt, 8);
      check("basic_pop_cnt", pop_cnt, 8);
      check("basic_done_cyc", done_cyc - t_acc, 13);
      check("basic_done_after_pop", done_cyc - last_pop_cyc, 1);
      check("basic_left", exp_q.size(), 0);

      // write collision: three write cycles while column 2 is pending
      clear_stats();
      exp_addr(16'h100); exp_addr(16'h101); exp_addr(16'h102); exp_addr(16'h103);
      exp_addr(16'h110); exp_addr(16'h111); exp_addr(16'h112); exp_addr(16'h113);
      send_cfg(16'h100, 16'd4, 16'd2, 16'h10);
      @(posedge clk); #1;
      @(posedge clk); #1;
      mem_wr_val = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("coll_hold_addr", mem_rd_addr, 16'h102);
         check("coll_rd_blocked", mem_rd_val, 0);
         @(posedge clk); #1;
      end
      mem_wr_val = 1'b0;
      wait_done(100);
      check("coll_rd_cnt", rd_cnt, 8);
      check("coll_pop_cnt", pop_cnt, 8);
      check("coll_last_rd", last_rd_cyc - t_acc, 11);

      // backpressure: 16 words, consumer stalled for 20 cycles
      clear_stats();
      img_rdy = 1'b0;
      for (int i = 0; i < 16; i++) exp_addr(AW'(16'h200 + i));
      send_cfg(16'h200, 16'd16, 16'd1, 16'h0);
      repeat (20) @(posedge clk);
      #1;
      check("bp_outstanding", rd_cnt, 8);
      check("bp_img_val", img_val, 1);
      img_rdy = 1'b1;
      @(posedge clk); #1;
      check("bp_no_issue_before_pop", rd_cnt, 8);
      @(posedge clk); #1;
      check("bp_resume_issue", rd_cnt, 9);
      wait_done(200);
      check("bp_rd_cnt", rd_cnt, 16);
      check("bp_pop_cnt", pop_cnt, 16);

      // address wrap
      clear_stats();
      exp_addr(16'hFFFE); exp_addr(16'hFFFF); exp_addr(16'h0000); exp_addr(16'h0001);
      send_cfg(16'hFFFE, 16'd4, 16'd1, 16'h0);
      wait_done(100);
      check("wrap_rd_cnt", rd_cnt, 4);
      check("wrap_pop_cnt", pop_cnt, 4);

      // zero-size regions
      clear_stats();
      send_cfg(16'h50, 16'd5, 16'd0, 16'h1);
      check("zero_done_t1", done, 1);
      check("zero_cfg_rdy_t1", cfg_rdy, 0);
      @(posedge clk); #1;
      check("zero_cfg_rdy_t2", cfg_rdy, 1);
      check("zero_done_t2", done, 0);
      send_cfg(16'h50, 16'd0, 16'd3, 16'h1);
      check("zero_cols_done_t1", done, 1);
      repeat (4) @(posedge clk);
      #1;
      check("zero_rd_cnt", rd_cnt, 0);
      check("zero_done_cnt", done_cnt, 2);

      // reset with three reads in flight
      clear_stats();
      for (int i = 0; i < 8; i++) exp_addr(AW'(16'h300 + i));
      send_cfg(16'h300, 16'd8, 16'd1, 16'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_idle_outputs("midrst");
      check("midrst_issued", rd_cnt, 3);
      clear_stats();
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         check("stale_img_val", img_val, 0);
      end
      check("stale_busy", busy, 0);
      exp_addr(16'h400); exp_addr(16'h401); exp_addr(16'h402);
      exp_addr(16'h408); exp_addr(16'h409); exp_addr(16'h40A);
      send_cfg(16'h400, 16'd3, 16'd2, 16'h8);
      wait_done(100);
      check("post_rst_first_val", first_val_cyc - t_acc, 5);
      check("post_rst_pop_cnt", pop_cnt, 6);
      check("post_rst_done_after_pop", done_cyc - last_pop_cyc, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/image_rd_ctrl.md
# image_rd_ctrl

Read-side controller for the image memory. Given a 2-D region descriptor, it walks the region row by row and issues one read address per cycle on the memory read port. It absorbs the fixed 3-cycle read latency and the memory's write-over-read priority, then delivers the returned words as a ready/valid stream with backpressure to the convolution datapath. Credit-based flow control guarantees every returned word has a FIFO slot.

## Interface
- GROUP_NB, default 4: pixels per memory read word.
- IMG_WIDTH, default 16: bits per pixel.
- MEM_AWIDTH, default 16: memory address width; also the width of the row/col counts.
- FIFO_DEPTH, default 8: return FIFO depth. Must be ≥1. Full rate requires ≥5.
- clk  in  1  sole clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- cfg_val  in  1  descriptor valid.
- cfg_rdy  out  1  high only in IDLE.
- cfg_base  in  MEM_AWIDTH  first address.
- cfg_cols  in  MEM_AWIDTH  words per row.
- cfg_rows  in  MEM_AWIDTH  row count.
- cfg_pitch  in  MEM_AWIDTH  address step between row starts.
- mem_wr_val  in  1  memory write-port request this cycle; a read issued in the same cycle would be dropped.
- mem_rd_val  out  1  read request.
- mem_rd_addr  out  MEM_AWIDTH  read address.
- mem_rd_data  in  GROUP_NB*IMG_WIDTH  returned word.
- mem_rd_data_val  in  1  returned word valid, exactly 3 cycles after an accepted mem_rd_val.
- img_data  out  GROUP_NB*IMG_WIDTH  stream data (FIFO head).
- img_val  out  1  stream valid.
- img_rdy  in  1  stream ready.
- img_last  out  1  marks the final word of the region.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse when the region completes.

## Operation
- States:
  - IDLE → RUN on cfg_val&cfg_rdy, with cfg_rows≠0 and cfg_cols≠0.
  - IDLE → DONE if either count is 0 (no reads are issued).
  - RUN → DRAIN when the last address is accepted.
  - DRAIN → DONE when in-flight = 0, the FIFO is empty, and the last word has been popped.
  - DONE → IDLE unconditionally after one cycle; done=1 only in DONE.
- Descriptor fields are registered on acceptance. Changes on the cfg inputs after acceptance are ignored.
- Address walk: row_start = base; addr = row_start + col.
  - After col = cols−1: col ← 0, row_start ← row_start + pitch, row ← row+1.
  - All address arithmetic wraps mod 2^MEM_AWIDTH.
- Issue condition:
  - issue = (state==RUN) & (fifo_count + inflight < FIFO_DEPTH).
  - mem_rd_val = issue & ~mem_wr_val (combinational).
  - Counters advance only when mem_rd_val=1. While mem_wr_val is high, the address holds.
- Counters:
  - inflight increments on mem_rd_val and decrements on mem_rd_data_val. Both in the same cycle leaves it unchanged.
  - Range is 0..FIFO_DEPTH.
- FIFO:
  - Push on mem_rd_data_val; pop on img_val&img_rdy. Simultaneous push and pop is legal.
  - By construction of the credit check it can never overflow; an overflow is a verification error.
- img_last: high with the FIFO head iff that word is the (rows·cols)-th word. Tracked with a pop counter.
- mem_rd_data_val received while in IDLE is discarded (stale data after a reset) and does not change inflight.
- Reset values: state=IDLE, cfg_rdy=1, and all of the following 0: mem_rd_val, img_val, img_last, busy, done, inflight, fifo_count, all counters. mem_rd_addr and img_data are don't-care.
- Reset mid-operation: the region is abandoned, the FIFO is flushed, and there is no done pulse.

## Timing
- Descriptor accepted at cycle T: first mem_rd_val at T+1 (if mem_wr_val=0), data push at T+4, img_val at T+5.
- Sustained throughput is 1 word/cycle with img_rdy=1, no writes, and FIFO_DEPTH≥5.
- Stalls:
  - img_rdy=0 stops issue once fifo_count+inflight reaches FIFO_DEPTH.
  - Issue resumes the cycle after a pop frees a credit.
- done pulses the cycle after the final pop. cfg_rdy rises the cycle after done.
- A zero-size region produces done at T+1 and cfg_rdy at T+2.

## Test plan
- Basic region: base=0x10, cols=4, rows=2, pitch=0x20, img_rdy=1.
  - Addresses: 0x10–0x13, then 0x30–0x33, on consecutive cycles from T+1.
  - 8 words out in order, starting at T+5; img_last on the 8th word; done one cycle later.
- Write collision: mem_wr_val held high for 3 cycles mid-row.
  - mem_rd_val is low for exactly those cycles and the address holds.
  - No words lost or duplicated; total output is still 8.
- Backpressure: img_rdy=0 for 20 cycles, FIFO_DEPTH=8.
  - Issue stops at 8 outstanding.
  - No overflow; the sequence is intact after img_rdy returns.
- Wrap: base=0xFFFE, cols=4, rows=1 (MEM_AWIDTH=16).
  - Addresses: 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Zero size: rows=0.
  - No mem_rd_val; done at T+1; cfg_rdy high again at T+2.
- Reset mid-RUN with 3 reads in flight.
  - All outputs take their reset values immediately.
  - Late mem_rd_data_val pulses are ignored; a new descriptor afterwards runs normally.
